// File: rtl/data_sync.sv
// data_sync: destination-domain bus synchronizer.
//   A source-domain level enable is passed through a NUM_STAGES flop chain;
//   its rising edge captures the quasi-static source bus into a holding
//   register that is offered to the local consumer with valid/ready.
//   A word replaced before being accepted is flagged as an overrun and
//   counted in a saturating drop counter.
//
// Ports
//   clk          in   destination-domain clock
//   rst          in   synchronous active-high reset (from this domain's reset synchronizer)
//   unsync_bus   in   [BUS_WIDTH-1:0] source-domain data, stable while bus_enable is high
//   bus_enable   in   source-domain level enable
//   out_ready    in   consumer accepts sync_bus this cycle
//   overrun_clr  in   synchronous clear of overrun and drop_cnt
//   sync_bus     out  [BUS_WIDTH-1:0] registered captured word
//   enable_pulse out  one-cycle strobe coincident with a new sync_bus value
//   out_valid    out  sync_bus holds an unconsumed word
//   overrun      out  sticky: a word was replaced before being consumed
//   drop_cnt     out  [7:0] saturating count of dropped words
module data_sync #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  input  logic                 out_ready,
  input  logic                 overrun_clr,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 out_valid,
  output logic                 overrun,
  output logic [7:0]           drop_cnt
);

  logic [NUM_STAGES-1:0] r_stage;
  logic                  r_en_d;
  logic                  w_en_s;
  logic                  w_rise;
  logic                  w_drop;
  logic [7:0]            w_drop_inc;

  assign w_en_s     = r_stage[NUM_STAGES-1];
  assign w_rise     = w_en_s & ~r_en_d;
  // A new word arriving while the held one is neither accepted nor free.
  assign w_drop     = w_rise & out_valid & ~out_ready;
  assign w_drop_inc = (drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage      <= '0;
      r_en_d       <= 1'b0;
      sync_bus     <= '0;
      enable_pulse <= 1'b0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      // Plain shift chain: no logic between synchronizer stages.
      r_stage      <= {r_stage[NUM_STAGES-2:0], bus_enable};
      r_en_d       <= w_en_s;
      enable_pulse <= w_rise;

      if (w_rise) begin
        sync_bus  <= unsync_bus;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // A drop event at the same edge as a clear wins: the clear is applied
      // first, then the event is counted from zero.
      if (w_drop) begin
        overrun  <= 1'b1;
        drop_cnt <= overrun_clr ? 8'd1 : w_drop_inc;
      end else if (overrun_clr) begin
        overrun  <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_sync.sv
module tb_data_sync;

  logic       clk;
  logic       rst;
  logic [7:0] unsync_bus;
  logic       bus_enable;
  logic       out_ready;
  logic       overrun_clr;
  logic [7:0] sync_bus;
  logic       enable_pulse;
  logic       out_valid;
  logic       overrun;
  logic [7:0] drop_cnt;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int          n_checks;
  int          n_fails;

  data_sync #(
    .NUM_STAGES(2),
    .BUS_WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .unsync_bus  (unsync_bus),
    .bus_enable  (bus_enable),
    .out_ready   (out_ready),
    .overrun_clr (overrun_clr),
    .sync_bus    (sync_bus),
    .enable_pulse(enable_pulse),
    .out_valid   (out_valid),
    .overrun     (overrun),
    .drop_cnt    (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every strobe must match the oldest expected word and its edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (cyc > 0 && enable_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_edge", cyc, e.cyc);
        check("pulse_data", {24'd0, sync_bus}, {24'd0, e.data});
        check("valid_at_pulse", {31'd0, out_valid}, 32'd1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enable first sampled at the next edge; strobe visible 3 edges from now.
  task automatic start_word(input logic [7:0] d);
    exp_t e;
    unsync_bus = d;
    bus_enable = 1'b1;
    e.data = d;
    e.cyc  = cyc + 3;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input int hi, input int lo);
    start_word(d);
    step(hi);
    bus_enable = 1'b0;
    step(lo);
  endtask

  task automatic check_outs(string tag, logic [7:0] sb, logic pl, logic v,
                            logic ov, logic [7:0] dc);
    check({tag, "_sync_bus"}, {24'd0, sync_bus}, {24'd0, sb});
    check({tag, "_pulse"}, {31'd0, enable_pulse}, {31'd0, pl});
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, ov});
    check({tag, "_drop_cnt"}, {24'd0, drop_cnt}, {24'd0, dc});
  endtask

  initial begin
    exp_t e;
    n_checks    = 0;
    n_fails     = 0;
    rst         = 1'b1;
    bus_enable  = 1'b1;
    unsync_bus  = 8'hFF;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;

    // Reset with enable already high.
    step(2);
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    rst       = 1'b0;
    out_ready = 1'b1;
    e.data = 8'hFF;
    e.cyc  = cyc + 3;
    exp_q.push_back(e);
    step(1);
    check_outs("post_reset_e1", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    step(7);
    bus_enable = 1'b0;
    step(4);
    check_outs("post_reset_done", 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);

    // Single transfer, consumer always ready.
    send(8'hA5, 5, 4);
    check_outs("single", 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);

    // Hold until ready.
    out_ready = 1'b0;
    send(8'h3C, 5, 4);
    for (int unsigned i = 0; i < 20; i++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {24'd0, sync_bus}, 32'h3C);
      step(1);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check_outs("hold_accept", 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00);

    // Overrun and saturation.
    send(8'h11, 4, 3);
    send(8'h22, 4, 3);
    check_outs("overrun1", 8'h22, 1'b0, 1'b1, 1'b1, 8'd1);
    for (int unsigned i = 0; i < 299; i++) send(i[7:0], 4, 3);
    check_outs("overrun_sat", 8'd42, 1'b0, 1'b1, 1'b1, 8'd255);

    // Clear coincident with a drop: the drop wins and counts from zero.
    start_word(8'h66);
    step(2);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check_outs("clr_vs_drop", 8'h66, 1'b1, 1'b1, 1'b1, 8'd1);
    step(2);
    bus_enable = 1'b0;
    step(3);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check_outs("clr", 8'h66, 1'b0, 1'b1, 1'b0, 8'd0);

    // Simultaneous accept and load: ready only at the rise edge.
    start_word(8'h55);
    step(2);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check_outs("simul", 8'h55, 1'b1, 1'b1, 1'b0, 8'd0);
    step(2);
    bus_enable = 1'b0;
    step(3);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("simul_drain_valid", {31'd0, out_valid}, 32'd0);

    // Reset one edge after the enable is first sampled.
    unsync_bus = 8'h77;
    bus_enable = 1'b1;
    step(1);
    rst = 1'b1;
    step(2);
    check_outs("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    e.data = 8'h77;
    e.cyc  = cyc + 3;
    exp_q.push_back(e);
    step(10);
    check_outs("mid_reset_after", 8'h77, 1'b0, 1'b1, 1'b0, 8'd0);
    bus_enable = 1'b0;
    step(4);

    check("pending_words", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
